// File: rtl/alu_exec_unit_if.sv
// Request/response bus of the execute-stage ALU.
// Both directions use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; the source holds its payload until then.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, alu_control, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_control, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute-stage ALU: one-cycle logic/arith/compare, iterative shifts.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a barrel shifter.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_exec_unit_if.slave       bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic [WIDTH-1:0] alu_comb;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             start_shift;
  logic             load_result;

  assign shamt  = bus.operand_b[SHW-1:0];
  assign accept = bus.in_valid && (state_q == IDLE);

  always_comb begin
    alu_comb = '0;
    case (bus.alu_control)
      4'b0000: alu_comb = bus.operand_a & bus.operand_b;
      4'b0001: alu_comb = bus.operand_a | bus.operand_b;
      4'b0011: alu_comb = bus.operand_a ^ bus.operand_b;
      4'b0110: alu_comb = bus.operand_a - bus.operand_b;
      4'b1000: alu_comb = {{(WIDTH-1){1'b0}},
                           ($signed(bus.operand_a) < $signed(bus.operand_b))};
      4'b1001: alu_comb = {{(WIDTH-1){1'b0}}, (bus.operand_a < bus.operand_b)};
`ifdef ALU_FAST_SHIFT_EN
      4'b0100: alu_comb = bus.operand_a << shamt;
      4'b0101: alu_comb = bus.operand_a >> shamt;
      4'b0111: alu_comb = WIDTH'($signed(bus.operand_a) >>> shamt);
`else
      // Only reached with a zero shift amount; non-zero amounts go iterative.
      4'b0100, 4'b0101, 4'b0111: alu_comb = bus.operand_a;
`endif
      default: alu_comb = bus.operand_a + bus.operand_b;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign start_shift = 1'b0;
`else
  logic [SHW-1:0]   cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] shift_one;
  logic             is_shift;

  assign is_shift    = (bus.alu_control == 4'b0100) || (bus.alu_control == 4'b0101) ||
                       (bus.alu_control == 4'b0111);
  assign start_shift = accept && is_shift && (shamt != '0);

  // op_q holds alu_control[1:0]: 00 SLL, 01 SRL, 11 SRA.
  always_comb begin
    shift_one = '0;
    case (op_q)
      2'b00:   shift_one = {data_q[WIDTH-2:0], 1'b0};
      2'b01:   shift_one = {1'b0, data_q[WIDTH-1:1]};
      default: shift_one = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      op_q  <= 2'b00;
    end else if (start_shift) begin
      cnt_q <= shamt;
      op_q  <= bus.alu_control[1:0];
    end else if (state_q == SHIFT) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end
`endif

  assign load_result = accept && !start_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      zero_q <= 1'b0;
    end else if (load_result) begin
      data_q <= alu_comb;
      zero_q <= (alu_comb == '0);
    end
`ifndef ALU_FAST_SHIFT_EN
    else if (start_shift) begin
      data_q <= bus.operand_a;
    end else if (state_q == SHIFT) begin
      data_q <= shift_one;
      if (cnt_q == SHW'(1)) zero_q <= (shift_one == '0);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_shift)      state_d = SHIFT;
        else if (accept)      state_d = DONE;
      end
`ifndef ALU_FAST_SHIFT_EN
      SHIFT: begin
        if (cnt_q == SHW'(1)) state_d = DONE;
      end
`endif
      DONE: begin
        if (bus.out_ready)    state_d = IDLE;
      end
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on registered state only.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = data_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute-stage ALU that consumes the 4-bit `alu_control` code produced by the ALU control decoder and returns a result plus a zero flag for branch resolution. Operands and code are accepted on a valid/ready handshake. Logic, add/sub and compare ops complete in one cycle. Shifts use an iterative one-bit-per-cycle shifter unless the barrel-shift option is compiled in. It sits between the decode/register-read stage and the writeback/branch logic.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a power of two, at least 8.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low. The block has one clock.
- `in_valid`, input, 1: operation request.
- `in_ready`, output, 1: block can accept a request.
- `alu_control`, input, 4: operation code.
- `operand_a`, input, `WIDTH`: first operand (rs1).
- `operand_b`, input, `WIDTH`: second operand (rs2 or immediate). Shift amount is `operand_b[SHW-1:0]`.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer takes the result.
- `result`, output, `WIDTH`: operation result.
- `zero`, output, 1: high when `result` is all zeros. Valid only while `out_valid` is high.

## Operation
- Codes:
  - 0000: AND
  - 0001: OR
  - 0010: ADD
  - 0011: XOR
  - 0100: SLL
  - 0101: SRL
  - 0110: SUB
  - 0111: SRA
  - 1000: SLT (signed)
  - 1001: SLTU
  - 1010–1111: executed as ADD
- ADD and SUB wrap modulo 2^WIDTH. No carry or overflow outputs.
- SLT and SLTU return 1 or 0, zero-extended to `WIDTH`.
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: `in_ready`=0, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- Transitions:
  - IDLE → DONE on accept of a non-shift op. Result is registered at the accept edge.
  - IDLE → DONE on accept of a shift op with shift amount 0. Result equals `operand_a`.
  - IDLE → SHIFT on accept of a shift op with shift amount > 0.
    - `operand_a` loads into the working register.
    - Down-counter (`SHW` bits) loads the shift amount.
    - The op type (SLL/SRL/SRA) is latched.
  - SHIFT: each cycle, shift the working register one bit and decrement the counter.
    - SLL fills zeros at the LSB.
    - SRL fills zeros at the MSB.
    - SRA replicates the MSB.
    - When the counter reads 1 at a clock edge, perform the final shift and go to DONE.
  - DONE → IDLE on `out_ready`=1.
- `result` and `zero` are held stable throughout DONE.
- Inputs are sampled only at the accept edge. Changes on `operand_*` or `alu_control` at other times are ignored.
- No new request is accepted in DONE, even when `out_ready` is high. Peak throughput is one op per 2 cycles.
- `zero` is computed from the final result and registered with it.

## Timing
- Reset (async assert, any state): state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `zero`=0, counter=0.
- An operation in progress is discarded at reset. Nothing is emitted after reset release.
- Reset deassertion is synchronised externally. The first accept is possible on the first rising edge with `rst_n` high.
- Latency from the accept edge to the edge after which `out_valid` is high:
  - Non-shift op: 1 cycle.
  - Shift op: 1 + shamt cycles. Max is `WIDTH` cycles (shamt = `WIDTH`-1).
- Handshake transfers at a rising edge with valid and ready both high.
- `in_ready` and `out_valid` are driven purely from registered state. There is no combinational path from `out_ready` or `in_valid`.

## Configuration
- `ALU_FAST_SHIFT_EN` defined:
  - Shifts use a combinational barrel shifter.
  - All codes have 1-cycle latency.
  - The SHIFT state and counter are not built.
- `ALU_FAST_SHIFT_EN` undefined: the iterative shifter described above is built.
- Results are bit-identical in both builds. Only latency differs.

## Test plan
- ADD: a=5, b=7, code 0010.
  - Expect `out_valid` 1 cycle after accept, result=12, zero=0.
  - Repeat with code 1111: result=12.
- SUB: a=3, b=3, code 0110.
  - Expect result=0, zero=1.
  - Repeat with a=0, b=1: result=0xFFFFFFFF, zero=0.
- Compare: a=0xFFFFFFFF, b=1.
  - SLT: result=1.
  - SLTU: result=0.
- SRA: a=0x80000000, b=4.
  - Expect result=0xF8000000, `out_valid` 5 cycles after accept.
  - SRL with the same operands: 0x08000000.
  - SLL: a=1, b=31 gives 0x80000000 after 32 cycles.
  - SLL: a=0x1234, b=0 gives 0x1234 after 1 cycle.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE.
  - `result`, `zero` and `out_valid` stay stable.
  - `in_ready` stays 0.
  - When `out_ready` rises, IDLE follows on the next cycle.
- Reset mid-operation: assert `rst_n`=0 during the 3rd SHIFT cycle of SLL by 20.
  - All outputs immediately go to their reset values.
  - After release, no stale `out_valid`.
  - A new ADD completes normally.
